// File: rtl/spi_read_arbiter_if.sv
// Requester and SPI-engine side bundle for spi_read_arbiter.
// slave: the arbiter's view; master: the clients and engine driving it.
interface spi_read_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;
  logic [NREQ-1:0] err;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic            eng_rd;
  logic            eng_d_ready;
  logic [DW-1:0]   eng_d;

  modport slave (
    input  req, eng_d_ready, eng_d,
    output gnt, done, err, rdata, busy, eng_rd
  );

  modport master (
    output req, eng_d_ready, eng_d,
    input  gnt, done, err, rdata, busy, eng_rd
  );
endinterface

// File: rtl/spi_read_arbiter.sv
// Round-robin arbiter sharing one SPI read engine among NREQ requesters.
// Runs the rd / d_ready / d level handshake for the winner, returns the word
// with a done pulse, and aborts with an err pulse if the engine stalls.
module spi_read_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 16,
  parameter int TIMEOUT = 4095,
  parameter int HOLDOFF = 255
) (
  input logic              clk,
  input logic              rst_l,
  spi_read_arbiter_if.slave bus
);
  localparam int          IW      = $clog2(NREQ);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] HOLD_V  = 16'(HOLDOFF);

  typedef enum logic [2:0] {IDLE, REQ, CAPT, ACK, DONE, ABORT, DRAIN} state_t;

  state_t          state;
  logic [1:0]      sync_pipe;
  logic            rdy_s;
  logic [IW-1:0]   last;
  logic [IW-1:0]   win_idx;
  logic [NREQ-1:0] win_oh;
  logic            found;
  logic [15:0]     timer;
  logic [15:0]     timer_inc;
  logic [15:0]     hold;
  logic [NREQ-1:0] gnt_q, done_q, err_q;
  logic [DW-1:0]   rdata_q;
  logic            busy_q, eng_rd_q;

  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.rdata  = rdata_q;
  assign bus.busy   = busy_q;
  assign bus.eng_rd = eng_rd_q;

  assign rdy_s     = sync_pipe[1];
  assign timer_inc = (timer == 16'hFFFF) ? timer : timer + 16'd1;
  assign win_oh    = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;

  // Two-flop synchroniser for the engine's asynchronous data-ready.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[0], bus.eng_d_ready};
  end

  // Round-robin pick: first set req bit scanning from last+1, wrapping.
  always_comb begin
    win_idx = last;
    found   = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && bus.req[(int'(last) + i) % NREQ]) begin
        found   = 1'b1;
        win_idx = IW'((int'(last) + i) % NREQ);
      end
    end
  end

  // Transaction FSM; every output is a register updated on the transition
  // into the state where it must be visible.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state    <= IDLE;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      eng_rd_q <= 1'b0;
      last     <= IW'(NREQ - 1);
      timer    <= '0;
      hold     <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            gnt_q    <= win_oh;
            last     <= win_idx;
            eng_rd_q <= 1'b1;
            busy_q   <= 1'b1;
            timer    <= '0;
            state    <= REQ;
          end
        end
        REQ: begin
          if (rdy_s) begin
            state <= CAPT;
          end else if (timer == TO_LAST) begin
            err_q    <= gnt_q;
            eng_rd_q <= 1'b0;
            state    <= ABORT;
          end else begin
            timer <= timer_inc;
          end
        end
        CAPT: begin
          rdata_q  <= bus.eng_d;
          eng_rd_q <= 1'b0;
          timer    <= '0;
          state    <= ACK;
        end
        ACK: begin
          if (!rdy_s) begin
            done_q <= gnt_q;
            state  <= DONE;
          end else if (timer == TO_LAST) begin
            err_q    <= gnt_q;
            eng_rd_q <= 1'b0;
            state    <= ABORT;
          end else begin
            timer <= timer_inc;
          end
        end
        DONE: begin
          gnt_q  <= '0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        ABORT: begin
          gnt_q <= '0;
          hold  <= HOLD_V;
          state <= DRAIN;
        end
        // Engine may still be mid-frame: wait out the holdoff and for d_ready
        // to fall before another read can be issued.
        DRAIN: begin
          if (hold != 16'd0) begin
            hold <= hold - 16'd1;
          end else if (!rdy_s) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
